seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, datapath width; SHALL be a power of two, minimum 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands and op presented.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 A, B  input  WIDTH each  operands; for shifts, B[$clog2(WIDTH)-1:0] is the shift amount k.
REQ-007 op  input  3  0 NOP, 1 OR, 2 AND, 3 ADD, 4 SUB, 5 SHL, 6 SHR (logical), 7 SRA.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 out  output  WIDTH  registered result.
REQ-011 zero, negative, carry, overflow  output  1 each  registered flags.

Function
REQ-012 Accept SHALL occur on a rising edge with in_valid && in_ready; A, B and op are captured at that edge.
REQ-013 in_ready SHALL be 1 only in state IDLE; no new operation is accepted while one is in flight or held.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE: IDLE->DONE on accept of op 0-4, or of op 5-7 with k=0; IDLE->SHIFT on accept of op 5-7 with k>0; SHIFT->DONE after exactly k shift cycles; DONE->IDLE on out_valid && out_ready.
REQ-015 out_valid SHALL be 1 exactly in DONE; latency accept-to-out_valid is 1 cycle for op 0-4 or k=0, k+1 cycles for shifts.
REQ-016 SHIFT SHALL move the working register one bit per cycle; SHL fills 0 at LSB, SHR fills 0 at MSB, SRA replicates MSB.
REQ-017 NOP SHALL produce out=0, carry=0, overflow=0.
REQ-018 OR/AND SHALL produce bitwise results; carry=0, overflow=0.
REQ-019 ADD SHALL produce A+B mod 2^WIDTH; carry = carry-out of MSB; overflow = signed two's-complement overflow.
REQ-020 SUB SHALL produce A-B mod 2^WIDTH; carry=1 when A>=B unsigned (no borrow); overflow = signed overflow of A-B.
REQ-021 Shifts SHALL set carry to the last bit shifted out (0 when k=0); overflow=0.
REQ-022 zero SHALL be 1 iff out==0; negative SHALL equal out[WIDTH-1]; both for every op.
REQ-023 While out_valid && !out_ready, out and all flags SHALL hold stable; in_valid is ignored.
REQ-024 in_valid and out_ready asserted in the same DONE cycle SHALL complete the handshake only; the new operation is accepted no earlier than the following IDLE cycle.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, out=0, zero=0, negative=0, carry=0, overflow=0, out_valid=0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no output; in_ready=1 on the first edge after rst_n deasserts.

Structure
REQ-027 Package seq_alu_pkg SHALL hold the op encoding enum (3 bits) and FSM state enum.
REQ-028 One sub-module, seq_alu_shift_step, SHALL implement a single combinational 1-bit shift (direction, arithmetic select, shifted-out bit); the FSM iterates it.
REQ-029 ADD/SUB SHALL share one adder (B inverted, carry-in 1 for SUB).

Verification (WIDTH=8)
REQ-030 ADD A=0x7F B=0x01 -> out=0x80, negative=1, overflow=1, carry=0, zero=0, out_valid 1 cycle after accept.
REQ-031 SUB A=0x05 B=0x05 -> out=0x00, zero=1, carry=1, overflow=0; NOP A=0xFF B=0xFF -> out=0x00, zero=1.
REQ-032 SHL A=0x81 B=3 -> out=0x08, carry=0, out_valid 4 cycles after accept; SRA A=0x90 B=2 -> out=0xE4, negative=1, carry=0.
REQ-033 Backpressure: ADD result with out_ready=0 for 3 cycles -> out/flags stable, in_ready=0, a concurrent in_valid op is not accepted; release -> IDLE next cycle.
REQ-034 rst_n pulsed low during SHL A=0x01 B=7 at cycle 3 -> outputs reset immediately, out_valid never asserted, in_ready=1 after release.
REQ-035 SHR A=0x80 B=0 -> out=0x80, carry=0, latency 1 cycle.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// ============================================================================
//  Module   : seq_alu_pkg
//  Contents : Op encoding and FSM state types shared by the sequential ALU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    localparam int c_OP_W    = 3;
    localparam int c_STATE_W = 2;

    typedef enum logic [c_OP_W-1:0] {
        OP_NOP = 3'd0,
        OP_OR  = 3'd1,
        OP_AND = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_SRA = 3'd7
    } op_e;

    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift_op(input op_e i_op);
        return (i_op == OP_SHL) || (i_op == OP_SHR) || (i_op == OP_SRA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_shift_step.sv
// ============================================================================
//  Module   : seq_alu_shift_step
//  Contents : Single combinational 1-bit shift (left / logical / arithmetic).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu_shift_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_left,
    input  logic             i_arith,
    output logic [WIDTH-1:0] o_data,
    output logic             o_shout
);

    logic w_fill;

    assign w_fill = i_arith & i_data[WIDTH-1];

    always_comb begin
        if (i_left) begin
            o_data  = {i_data[WIDTH-2:0], 1'b0};
            o_shout = i_data[WIDTH-1];
        end else begin
            o_data  = {w_fill, i_data[WIDTH-1:1]};
            o_shout = i_data[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
//  Module   : seq_alu
//  Contents : Handshaked ALU; logic/arith ops in one cycle, shifts iterated
//             one bit per cycle through seq_alu_shift_step.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam int c_SW = $clog2(WIDTH);

    state_e             r_state;
    state_e             w_next;
    op_e                r_op;
    logic [WIDTH-1:0]   r_out;
    logic [c_SW-1:0]    r_cnt;
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_ovf;

    op_e                w_op;
    logic [c_SW-1:0]    w_k;
    logic               w_accept;
    logic               w_multi;
    logic               w_sub;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_add_ovf;
    logic [WIDTH-1:0]   w_res;
    logic               w_res_c;
    logic               w_res_v;
    logic [WIDTH-1:0]   w_step;
    logic               w_shout;
    logic               w_last;

    assign w_op     = op_e'(op);
    assign w_k      = B[c_SW-1:0];
    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_multi  = is_shift_op(w_op) && (w_k != '0);
    assign w_last   = (r_cnt == c_SW'(1));

    // Shared adder: SUB is A + ~B + 1, so carry-out doubles as "no borrow".
    assign w_sub     = (w_op == OP_SUB);
    assign w_b_eff   = w_sub ? ~B : B;
    assign {w_cout, w_sum} = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    assign w_add_ovf = (A[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

    // Single-cycle result; shifts only reach here with k=0 and pass A through.
    always_comb begin
        w_res   = '0;
        w_res_c = 1'b0;
        w_res_v = 1'b0;
        case (w_op)
            OP_NOP:         w_res = '0;
            OP_OR:          w_res = A | B;
            OP_AND:         w_res = A & B;
            OP_ADD, OP_SUB: begin
                w_res   = w_sum;
                w_res_c = w_cout;
                w_res_v = w_add_ovf;
            end
            default:        w_res = A;
        endcase
    end

    seq_alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data  (r_out),
        .i_left  (r_op == OP_SHL),
        .i_arith (r_op == OP_SRA),
        .o_data  (w_step),
        .o_shout (w_shout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_multi ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_out doubles as the shift working register; it is only visible in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_NOP;
            r_out   <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= w_op;
                        if (w_multi) begin
                            r_out   <= A;
                            r_cnt   <= w_k;
                            r_carry <= 1'b0;
                            r_ovf   <= 1'b0;
                        end else begin
                            r_out   <= w_res;
                            r_zero  <= (w_res == '0);
                            r_neg   <= w_res[WIDTH-1];
                            r_carry <= w_res_c;
                            r_ovf   <= w_res_v;
                        end
                    end
                end
                S_SHIFT: begin
                    r_out   <= w_step;
                    r_carry <= w_shout;
                    r_zero  <= (w_step == '0);
                    r_neg   <= w_step[WIDTH-1];
                    r_cnt   <= r_cnt - c_SW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign zero      = r_zero;
    assign negative  = r_neg;
    assign carry     = r_carry;
    assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
//  Module   : tb_seq_alu
//  Contents : Self-checking bench for seq_alu (WIDTH=8): vector table,
//             randomized ops vs. arithmetic model, backpressure and reset.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [2:0]       op = 3'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eout;
        logic       ez;
        logic       en;
        logic       ec;
        logic       ev;
        int         elat;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic c, output logic v,
                         output int lat);
        int k, s, sa, sb;
        k  = int'(b[2:0]);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        lat = 1;
        case (o)
            3'd0: r = 8'h00;
            3'd1: r = a | b;
            3'd2: r = a & b;
            3'd3: begin
                s = int'(a) + int'(b);
                r = 8'(s);
                c = (s > 255);
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            3'd4: begin
                s = int'(a) - int'(b);
                r = 8'(s);
                c = (int'(a) >= int'(b));
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            3'd5: begin
                r = 8'(int'(a) << k);
                c = (k > 0) ? 1'((int'(a) >> (8 - k)) & 1) : 1'b0;
                lat = k + 1;
            end
            3'd6: begin
                r = 8'(int'(a) >> k);
                c = (k > 0) ? 1'((int'(a) >> (k - 1)) & 1) : 1'b0;
                lat = k + 1;
            end
            default: begin
                r = 8'(sa >>> k);
                c = (k > 0) ? 1'((int'(a) >> (k - 1)) & 1) : 1'b0;
                lat = k + 1;
            end
        endcase
    endtask

    task automatic run_op(input string nm, input vec_t t);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({nm, ".in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        op = t.op;
        A  = t.a;
        B  = t.b;
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 40);
        chk({nm, ".latency"}, lat, t.elat);
        chk({nm, ".out"}, int'(out), int'(t.eout));
        chk({nm, ".zero"}, int'(zero), int'(t.ez));
        chk({nm, ".negative"}, int'(negative), int'(t.en));
        chk({nm, ".carry"}, int'(carry), int'(t.ec));
        chk({nm, ".overflow"}, int'(overflow), int'(t.ev));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, ".idle_after"}, int'(in_ready), 1);
    endtask

    vec_t tbl[13];

    initial begin
        vec_t t;
        logic [7:0] r;
        logic c, v;
        int lat, seen;

        tbl[0]  = '{3'd3, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[1]  = '{3'd4, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[2]  = '{3'd0, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[3]  = '{3'd5, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        tbl[4]  = '{3'd7, 8'h90, 8'h02, 8'hE4, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        tbl[5]  = '{3'd6, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[6]  = '{3'd1, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[7]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{3'd3, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[9]  = '{3'd4, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[10] = '{3'd4, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[11] = '{3'd6, 8'h81, 8'h01, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[12] = '{3'd5, 8'hFF, 8'h07, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 8};

        // Reset state
        #12;
        chk("reset.out", int'(out), 0);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.flags", int'({zero, negative, carry, overflow}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.in_ready", int'(in_ready), 1);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i]);
        end

        for (int i = 0; i < 40; i++) begin
            t.op = 3'($urandom_range(0, 7));
            t.a  = 8'($urandom);
            t.b  = 8'($urandom);
            model(t.op, t.a, t.b, r, c, v, lat);
            t.eout = r;
            t.ez   = (r == 8'h00);
            t.en   = r[7];
            t.ec   = c;
            t.ev   = v;
            t.elat = lat;
            run_op($sformatf("rnd%0d_op%0d", i, t.op), t);
        end

        // Backpressure: result held while a competing op is presented
        in_valid = 1'b1; op = 3'd3; A = 8'h12; B = 8'h34;
        @(posedge clk); #1;
        op = 3'd1; A = 8'h0F; B = 8'hF0;
        chk("bp.valid", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.hold_out%0d", i), int'(out), 8'h46);
            chk($sformatf("bp.hold_flags%0d", i), int'({zero, negative, carry, overflow}), 0);
            chk($sformatf("bp.hold_valid%0d", i), int'(out_valid), 1);
            chk($sformatf("bp.in_ready%0d", i), int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.release_idle", int'(in_ready), 1);
        chk("bp.release_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.next_valid", int'(out_valid), 1);
        chk("bp.next_out", int'(out), 8'hFF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset pulse in the middle of a long shift
        in_valid = 1'b1; op = 3'd5; A = 8'h01; B = 8'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst.out", int'(out), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.flags", int'({zero, negative, carry, overflow}), 0);
        chk("rst.in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst.no_output", seen, 0);
        chk("rst.ready_after", int'(in_ready), 1);
        run_op("post_rst", tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
